// File: rtl/rv_isa_pkg.sv
// Shared RV32I decode constants, ALU operation enum, instruction-kind enum
// and immediate helpers used by the instr_decoder slice.
package rv_isa_pkg;

  // Major opcodes handled by the decoder
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // funct3 codes
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;

  // funct7 codes
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Phase values of the loop counter
  localparam logic [2:0] PH_FETCH   = 3'd1;
  localparam logic [2:0] PH_DECODE  = 3'd2;
  localparam logic [2:0] PH_EXECUTE = 3'd3;
  localparam logic [2:0] PH_COMMIT  = 3'd4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    KIND_NONE    = 3'd0,
    KIND_ALU     = 3'd1,
    KIND_LOAD    = 3'd2,
    KIND_STORE   = 3'd3,
    KIND_ILLEGAL = 3'd4
  } instr_kind_e;

  // Sign-extend an I-type immediate (ir[31:20])
  function automatic logic [31:0] imm_i(input logic [11:0] f);
    return {{20{f[11]}}, f};
  endfunction

  // Sign-extend an S-type immediate (ir[31:25], ir[11:7])
  function automatic logic [31:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, hi, lo};
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I integer ALU. Shift amount comes from b[4:0].
module rv_alu
  import rv_isa_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result
);

  // Select the operation result; arithmetic right shift replicates bit 31
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_XOR: result = a ^ b;
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SRA: result = $signed(a) >>> b[4:0];
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// Multi-phase RV32I subset decoder/executor with register file and data
// memory. loop=1 fetch, 2 decode/read, 3 execute, 4 commit; other values idle.
// Optional macro INSTR_DECODER_SHIFT_EN enables SLL/SRL/SRA/SLLI/SRLI/SRAI;
// without it those encodings are reported as illegal.
module instr_decoder
  import rv_isa_pkg::*;
#(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [2:0]  loop,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        illegal
);

  localparam int AW = $clog2(DMEM_WORDS);

`ifdef INSTR_DECODER_SHIFT_EN
  localparam logic SHIFT_EN = 1'b1;
`else
  localparam logic SHIFT_EN = 1'b0;
`endif

  // Architectural and pipeline state
  logic [31:0] rf_q   [32];
  logic [31:0] rf_d   [32];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] dmem_d [DMEM_WORDS];
  logic [31:0] ir_q, ir_d;
  instr_kind_e kind_q, kind_d;
  alu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        illegal_q, illegal_d;

  // Decode fields and helpers
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  instr_kind_e dec_kind;
  instr_kind_e kind_sel;
  alu_op_e     dec_op;
  logic [31:0] dec_b;
  logic        dec_shift;
  logic [31:0] alu_res;
  logic [AW-1:0] word_idx;

  assign opcode   = ir_q[6:0];
  assign f3       = ir_q[14:12];
  assign f7       = ir_q[31:25];
  assign rs1_val  = rf_q[ir_q[19:15]];
  assign rs2_val  = rf_q[ir_q[24:20]];
  assign word_idx = res_q[AW+1:2];
  assign kind_sel = (dec_shift && !SHIFT_EN) ? KIND_ILLEGAL : dec_kind;

  rv_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  // Classify the held instruction and choose ALU op and second operand
  always_comb begin
    dec_kind  = KIND_ILLEGAL;
    dec_op    = ALU_ADD;
    dec_b     = 32'd0;
    dec_shift = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_b = rs2_val;
        case (f3)
          F3_ADD_SUB: begin
            if (f7 == F7_BASE) begin
              dec_kind = KIND_ALU; dec_op = ALU_ADD;
            end else if (f7 == F7_ALT) begin
              dec_kind = KIND_ALU; dec_op = ALU_SUB;
            end else begin
              dec_kind = KIND_ILLEGAL;
            end
          end
          F3_XOR: dec_kind = (f7 == F7_BASE) ? KIND_ALU : KIND_ILLEGAL;
          F3_OR:  dec_kind = (f7 == F7_BASE) ? KIND_ALU : KIND_ILLEGAL;
          F3_AND: dec_kind = (f7 == F7_BASE) ? KIND_ALU : KIND_ILLEGAL;
          F3_SLL: begin
            dec_kind  = (f7 == F7_BASE) ? KIND_ALU : KIND_ILLEGAL;
            dec_shift = 1'b1;
          end
          F3_SRL_SRA: begin
            dec_shift = 1'b1;
            if (f7 == F7_BASE) begin
              dec_kind = KIND_ALU; dec_op = ALU_SRL;
            end else if (f7 == F7_ALT) begin
              dec_kind = KIND_ALU; dec_op = ALU_SRA;
            end else begin
              dec_kind = KIND_ILLEGAL;
            end
          end
          default: dec_kind = KIND_ILLEGAL;
        endcase
        if (f3 == F3_XOR) begin
          dec_op = ALU_XOR;
        end else if (f3 == F3_OR) begin
          dec_op = ALU_OR;
        end else if (f3 == F3_AND) begin
          dec_op = ALU_AND;
        end else if (f3 == F3_SLL) begin
          dec_op = ALU_SLL;
        end else begin
          dec_op = dec_op;
        end
      end
      OPC_OP_IMM: begin
        dec_b = imm_i(ir_q[31:20]);
        case (f3)
          F3_ADD_SUB: begin dec_kind = KIND_ALU; dec_op = ALU_ADD; end
          F3_XOR:     begin dec_kind = KIND_ALU; dec_op = ALU_XOR; end
          F3_OR:      begin dec_kind = KIND_ALU; dec_op = ALU_OR;  end
          F3_AND:     begin dec_kind = KIND_ALU; dec_op = ALU_AND; end
          F3_SLL: begin
            dec_shift = 1'b1;
            dec_op    = ALU_SLL;
            dec_kind  = (f7 == F7_BASE) ? KIND_ALU : KIND_ILLEGAL;
          end
          F3_SRL_SRA: begin
            dec_shift = 1'b1;
            if (f7 == F7_BASE) begin
              dec_kind = KIND_ALU; dec_op = ALU_SRL;
            end else if (f7 == F7_ALT) begin
              dec_kind = KIND_ALU; dec_op = ALU_SRA;
            end else begin
              dec_kind = KIND_ILLEGAL;
            end
          end
          default: dec_kind = KIND_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        dec_b    = imm_i(ir_q[31:20]);
        dec_kind = (f3 == F3_LW) ? KIND_LOAD : KIND_ILLEGAL;
      end
      OPC_STORE: begin
        dec_b    = imm_s(ir_q[31:25], ir_q[11:7]);
        dec_kind = (f3 == F3_SW) ? KIND_STORE : KIND_ILLEGAL;
      end
      default: dec_kind = KIND_ILLEGAL;
    endcase
  end

  // Per-phase next-state: only the phase named by loop advances any state
  always_comb begin
    ir_d        = ir_q;
    kind_d      = kind_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    sdata_d     = sdata_q;
    rd_d        = rd_q;
    res_d       = res_q;
    rf_d        = rf_q;
    dmem_d      = dmem_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    illegal_d   = 1'b0;
    case (loop)
      PH_FETCH: ir_d = instruction;
      PH_DECODE: begin
        kind_d  = kind_sel;
        op_d    = dec_op;
        a_d     = rs1_val;
        b_d     = dec_b;
        sdata_d = rs2_val;
        rd_d    = ir_q[11:7];
      end
      PH_EXECUTE: res_d = alu_res;
      PH_COMMIT: begin
        case (kind_q)
          KIND_ALU: begin
            wb_en_d       = 1'b1;
            wb_addr_d     = rd_q;
            wb_data_d     = res_q;
            rf_d[rd_q]    = res_q;
          end
          KIND_LOAD: begin
            wb_en_d       = 1'b1;
            wb_addr_d     = rd_q;
            wb_data_d     = dmem_q[word_idx];
            rf_d[rd_q]    = dmem_q[word_idx];
            mem_addr_d    = res_q;
          end
          KIND_STORE: begin
            mem_we_d         = 1'b1;
            mem_addr_d       = res_q;
            mem_wdata_d      = sdata_q;
            dmem_d[word_idx] = sdata_q;
          end
          KIND_ILLEGAL: illegal_d = 1'b1;
          default: illegal_d = 1'b0;
        endcase
      end
      default: ir_d = ir_q;
    endcase
    // x0 is hard-wired to zero; writes to it are dropped here
    rf_d[0] = 32'd0;
  end

  // State registers with asynchronous reset clearing all architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      for (int j = 0; j < DMEM_WORDS; j++) dmem_q[j] <= 32'd0;
      ir_q        <= 32'd0;
      kind_q      <= KIND_NONE;
      op_q        <= ALU_ADD;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      sdata_q     <= 32'd0;
      rd_q        <= 5'd0;
      res_q       <= 32'd0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      illegal_q   <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      dmem_q      <= dmem_d;
      ir_q        <= ir_d;
      kind_q      <= kind_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sdata_q     <= sdata_d;
      rd_q        <= rd_d;
      res_q       <= res_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      illegal_q   <= illegal_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed self-checking bench for instr_decoder (default DMEM_WORDS=64).
// Shift expectations follow INSTR_DECODER_SHIFT_EN as seen by this file.
module tb_instr_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [2:0]  loop;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        illegal;

  int checks;
  int errors;

  // Values captured one half-cycle after the phase-4 edge, and one cycle later
  logic        c_wb_en, c_mem_we, c_illegal, n_wb_en, n_mem_we, n_illegal;
  logic [4:0]  c_wb_addr;
  logic [31:0] c_wb_data, c_mem_addr, c_mem_wdata;

  instr_decoder #(.DMEM_WORDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .loop       (loop),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic exec(input logic [31:0] ins);
    for (int p = 1; p <= 4; p++) begin
      @(negedge clk);
      instruction = ins;
      loop = 3'(p);
    end
    @(negedge clk);
    loop        = 3'd0;
    c_wb_en     = wb_en;
    c_wb_addr   = wb_addr;
    c_wb_data   = wb_data;
    c_mem_we    = mem_we;
    c_mem_addr  = mem_addr;
    c_mem_wdata = mem_wdata;
    c_illegal   = illegal;
    @(negedge clk);
    n_wb_en   = wb_en;
    n_mem_we  = mem_we;
    n_illegal = illegal;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    loop = 3'd0;
    instruction = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_en, mem_we, illegal} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {wb_en, mem_we, illegal});
    end
    checks++;
    if ({wb_addr, wb_data, mem_addr, mem_wdata} !== 101'd0) begin
      errors++; $display("FAIL reset_buses got %h/%h/%h/%h want 0", wb_addr, wb_data, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addi();
    exec(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    checks++;
    if (c_wb_en !== 1'b1 || c_wb_addr !== 5'd1 || c_wb_data !== 32'h00000005) begin
      errors++; $display("FAIL addi_x1 got en=%b a=%0d d=%h want 1/1/00000005", c_wb_en, c_wb_addr, c_wb_data);
    end
    checks++;
    if (n_wb_en !== 1'b0) begin
      errors++; $display("FAIL wb_en_width got %b want 0", n_wb_en);
    end
    exec(enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011));
    checks++;
    if (c_wb_en !== 1'b1 || c_wb_addr !== 5'd2 || c_wb_data !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL addi_x2 got en=%b a=%0d d=%h want 1/2/fffffffd", c_wb_en, c_wb_addr, c_wb_data);
    end
  endtask

  task automatic test_rtype();
    exec(enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd3));
    checks++;
    if (c_wb_data !== 32'hFFFFFFF8 || c_wb_addr !== 5'd3) begin
      errors++; $display("FAIL xor got %h want fffffff8", c_wb_data);
    end
    exec(enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd3));
    checks++;
    if (c_wb_data !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL or got %h want fffffffd", c_wb_data);
    end
    exec(enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3));
    checks++;
    if (c_wb_data !== 32'h00000005) begin
      errors++; $display("FAIL and got %h want 00000005", c_wb_data);
    end
    exec(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4));
    checks++;
    if (c_wb_data !== 32'h00000008 || c_wb_addr !== 5'd4) begin
      errors++; $display("FAIL sub got %h want 00000008", c_wb_data);
    end
    exec(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd4));
    checks++;
    if (c_wb_data !== 32'h00000002) begin
      errors++; $display("FAIL add got %h want 00000002", c_wb_data);
    end
  endtask

  task automatic test_shift();
    logic [31:0] ins [4];
    logic [31:0] exp [4];
    ins[0] = enc_i(12'h401, 5'd2, 3'b101, 5'd5, 7'b0010011); exp[0] = 32'hFFFFFFFE;
    ins[1] = enc_i(12'h001, 5'd2, 3'b101, 5'd6, 7'b0010011); exp[1] = 32'h7FFFFFFE;
    ins[2] = enc_i(12'h004, 5'd1, 3'b001, 5'd7, 7'b0010011); exp[2] = 32'h00000050;
    ins[3] = enc_r(7'b0100000, 5'd1, 5'd2, 3'b101, 5'd10);   exp[3] = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      exec(ins[k]);
      checks++;
`ifdef INSTR_DECODER_SHIFT_EN
      if (c_wb_en !== 1'b1 || c_illegal !== 1'b0 || c_wb_data !== exp[k]) begin
        errors++; $display("FAIL shift_%0d got en=%b ill=%b d=%h want 1/0/%h", k, c_wb_en, c_illegal, c_wb_data, exp[k]);
      end
`else
      if (c_wb_en !== 1'b0 || c_illegal !== 1'b1) begin
        errors++; $display("FAIL shift_illegal_%0d got en=%b ill=%b want 0/1 (value would be %h)", k, c_wb_en, c_illegal, exp[k]);
      end
`endif
    end
  endtask

  task automatic test_mem();
    exec(enc_sw(12'd8, 5'd1, 5'd0));
    checks++;
    if (c_mem_we !== 1'b1 || c_mem_addr !== 32'd8 || c_mem_wdata !== 32'd5 || c_wb_en !== 1'b0) begin
      errors++; $display("FAIL sw got we=%b a=%h d=%h en=%b want 1/8/5/0", c_mem_we, c_mem_addr, c_mem_wdata, c_wb_en);
    end
    checks++;
    if (n_mem_we !== 1'b0) begin
      errors++; $display("FAIL mem_we_width got %b want 0", n_mem_we);
    end
    exec(enc_i(12'd8, 5'd0, 3'b010, 5'd8, 7'b0000011));
    checks++;
    if (c_wb_en !== 1'b1 || c_wb_addr !== 5'd8 || c_wb_data !== 32'd5 || c_mem_we !== 1'b0) begin
      errors++; $display("FAIL lw got en=%b a=%0d d=%h we=%b want 1/8/5/0", c_wb_en, c_wb_addr, c_wb_data, c_mem_we);
    end
    // 264 = 8 + 64*4 aliases word 2; byte offset 11 also selects word 2
    exec(enc_i(12'd264, 5'd0, 3'b010, 5'd11, 7'b0000011));
    checks++;
    if (c_wb_data !== 32'd5 || c_mem_addr !== 32'd264) begin
      errors++; $display("FAIL lw_alias got d=%h a=%h want 5/108", c_wb_data, c_mem_addr);
    end
    exec(enc_i(12'd11, 5'd0, 3'b010, 5'd11, 7'b0000011));
    checks++;
    if (c_wb_data !== 32'd5) begin
      errors++; $display("FAIL lw_lowbits got %h want 5", c_wb_data);
    end
  endtask

  task automatic test_x0_illegal();
    exec(enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011));
    checks++;
    if (c_wb_en !== 1'b1 || c_wb_addr !== 5'd0) begin
      errors++; $display("FAIL x0_write got en=%b a=%0d want 1/0", c_wb_en, c_wb_addr);
    end
    exec(enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd9));
    checks++;
    if (c_wb_data !== 32'd0 || c_wb_addr !== 5'd9) begin
      errors++; $display("FAIL x0_read got %h want 0", c_wb_data);
    end
    exec(32'hFFFFFFFF);
    checks++;
    if (c_illegal !== 1'b1 || c_wb_en !== 1'b0 || c_mem_we !== 1'b0 || n_illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_op got ill=%b en=%b we=%b next=%b want 1/0/0/0", c_illegal, c_wb_en, c_mem_we, n_illegal);
    end
    exec(enc_i(12'd0, 5'd31, 3'b000, 5'd13, 7'b0010011));
    checks++;
    if (c_wb_data !== 32'd0) begin
      errors++; $display("FAIL illegal_no_write got x31=%h want 0", c_wb_data);
    end
    exec(enc_i(12'd1, 5'd1, 3'b010, 5'd14, 7'b0010011));
    checks++;
    if (c_illegal !== 1'b1 || c_wb_en !== 1'b0) begin
      errors++; $display("FAIL slti_illegal got ill=%b en=%b want 1/0", c_illegal, c_wb_en);
    end
    exec(enc_i(12'd8, 5'd0, 3'b000, 5'd14, 7'b0000011));
    checks++;
    if (c_illegal !== 1'b1 || c_wb_en !== 1'b0) begin
      errors++; $display("FAIL lb_illegal got ill=%b en=%b want 1/0", c_illegal, c_wb_en);
    end
  endtask

  task automatic test_back_to_back();
    exec(enc_i(12'd1, 5'd0, 3'b000, 5'd14, 7'b0010011));
    exec(enc_i(12'd1, 5'd14, 3'b000, 5'd14, 7'b0010011));
    checks++;
    if (c_wb_data !== 32'd2) begin
      errors++; $display("FAIL back_to_back got %h want 2", c_wb_data);
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 1; p <= 3; p++) begin
      @(negedge clk);
      instruction = enc_i(12'd9, 5'd0, 3'b000, 5'd1, 7'b0010011);
      loop = 3'(p);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (wb_data !== 32'd0 || wb_addr !== 5'd0) begin
      errors++; $display("FAIL async_reset got d=%h a=%0d want 0/0", wb_data, wb_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    loop = 3'd4;
    @(negedge clk);
    loop = 3'd0;
    checks++;
    if (wb_en !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL aborted_commit got en=%b ill=%b want 0/0", wb_en, illegal);
    end
    exec(enc_i(12'd0, 5'd1, 3'b000, 5'd15, 7'b0010011));
    checks++;
    if (c_wb_data !== 32'd0) begin
      errors++; $display("FAIL x1_after_reset got %h want 0", c_wb_data);
    end
    exec(enc_i(12'd8, 5'd0, 3'b010, 5'd16, 7'b0000011));
    checks++;
    if (c_wb_data !== 32'd0) begin
      errors++; $display("FAIL dmem_after_reset got %h want 0", c_wb_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    loop = 3'd0;
    instruction = 32'd0;
    test_reset();
    test_addi();
    test_rtype();
    test_shift();
    test_mem();
    test_x0_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 64, number of 32-bit data-memory words (power of two, 4..1024).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instruction  input  32  RV32I instruction word, stable while loop is 1..4.
REQ-005 SHALL have port loop  input  3  phase counter, sequence 0,1,2,3,4,0,...; values 5..7 are idle.
REQ-006 SHALL have port wb_en  output  1  one-cycle pulse when a register write occurs.
REQ-007 SHALL have port wb_addr  output  5  destination register of the write.
REQ-008 SHALL have port wb_data  output  32  value written.
REQ-009 SHALL have port mem_we  output  1  one-cycle pulse when a store commits.
REQ-010 SHALL have port mem_addr  output  32  effective byte address of the last load/store.
REQ-011 SHALL have port mem_wdata  output  32  stored word.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse for an unsupported instruction.

Function
REQ-013 SHALL contain a 32x32 register file; x0 reads 0 and writes to x0 are discarded (wb_en still pulses, wb_addr=0).
REQ-014 SHALL contain a DMEM_WORDS x 32 data memory, word-addressed by mem_addr[log2(DMEM_WORDS)+1:2]; the upper address bits and bits [1:0] are ignored.
REQ-015 SHALL act only on rising clk edges where loop equals the phase below; all other edges hold state.
REQ-016 Phase 1: capture instruction into an internal instruction register.
REQ-017 Phase 2: decode opcode/funct3/funct7, read rs1/rs2, form the sign-extended immediate (I-type imm[11:0]=ir[31:20]; S-type ir[31:25],ir[11:7]).
REQ-018 Phase 3: compute the ALU result or the effective address rs1+imm (modulo 2^32).
REQ-019 Phase 4: commit the register write, load, or store and drive the output pulses for exactly this one cycle.
REQ-020 R-type (opcode 0110011): ADD, SUB (funct7=0100000), XOR, OR, AND, SLL, SRL, SRA (funct7=0100000); shift amount = rs2[4:0].
REQ-021 I-type ALU (opcode 0010011): ADDI, XORI, ORI, ANDI, SLLI, SRLI, SRAI; shamt = ir[24:20]; SRAI requires ir[31:25]=0100000.
REQ-022 Load (opcode 0000011, funct3=010 LW) writes the memory word to rd; store (opcode 0100011, funct3=010 SW) writes rs2 to memory and pulses mem_we.
REQ-023 Any other opcode/funct3/funct7 combination SHALL pulse illegal in phase 4 and change no architectural state.
REQ-024 SRA/SRAI SHALL replicate bit 31; SRL/SRLI/SLL/SLLI SHALL fill with zeros.
REQ-025 A write in phase 4 SHALL be visible to the next instruction's phase-2 read (no hazard).
REQ-026 If loop jumps out of sequence, the decoder SHALL simply execute each phase when it occurs, using the current register contents.

Reset
REQ-027 While rst is high: registers x1..x31, data memory, instruction register, and all outputs SHALL be 0.
REQ-028 Reset asserted mid-instruction SHALL abort it with no register or memory update.

Configuration
REQ-029 With macro INSTR_DECODER_SHIFT_EN defined, SLL/SRL/SRA/SLLI/SRLI/SRAI SHALL be executed; without it they SHALL be treated as illegal (REQ-023).

Structure
REQ-030 Opcode constants, funct3/funct7 codes, and the ALU-operation enum SHALL live in shared package rv_isa_pkg.
REQ-031 The combinational ALU SHALL be a separate sub-module named rv_alu (inputs a, b, op; output result).

Verification
REQ-032 ADDI x1,x0,5 then ADDI x2,x0,-3 -> wb_en pulses, wb_data=0x00000005 then 0xFFFFFFFD.
REQ-033 With x1=5, x2=0xFFFFFFFD: XOR x3,x1,x2 -> 0xFFFFFFF8; OR -> 0xFFFFFFFD; AND -> 0x00000005; SUB x4,x1,x2 -> 0x00000008.
REQ-034 With x2=0xFFFFFFFD: SRAI x5,x2,1 -> 0xFFFFFFFE; SRLI x6,x2,1 -> 0x7FFFFFFE; SLLI x7,x1,4 -> 0x00000050 (macro defined); without macro each pulses illegal, no wb_en.
REQ-035 SW x1,8(x0) -> mem_we pulse, mem_addr=8, mem_wdata=5; then LW x8,8(x0) -> wb_addr=8, wb_data=5.
REQ-036 ADDI x0,x0,7 then ADD x9,x0,x0 -> x9=0; opcode 1111111 -> illegal pulse only.
REQ-037 Assert rst during phase 3 of ADDI x1,x0,9 -> no write; after release x1 reads 0.
